sram_like_responder: RTL and testbench
======================================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, word-index width of the internal memory (2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..8, cycles from request acceptance to data_ok.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, reset value of the addr_ok throttle LFSR.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock, all state changes on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req  in  1  request valid from the initiator.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 wstrb  in  4  byte write enables; wstrb[i] covers wdata[8i+7:8i].
REQ-009 addr  in  32  byte address.
REQ-010 size  in  3  transfer size; accepted and ignored, wstrb is authoritative.
REQ-011 wdata  in  32  write data.
REQ-012 addr_ok  out  1  request accepted this cycle when req && addr_ok.
REQ-013 rdata  out  32  read data, valid only while data_ok is high.
REQ-014 data_ok  out  1  one-cycle response pulse, one per accepted request, in acceptance order.
REQ-015 stall_en  in  1  forces addr_ok low while high.
REQ-016 rand_en  in  1  enables pseudo-random addr_ok throttling.
REQ-017 pending  out  4  count of accepted requests not yet answered.

Function
REQ-018 SHALL assert addr_ok = !stall_en && (!rand_en || lfsr[0]); addr_ok does not depend on req.
REQ-019 SHALL use a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle regardless of req/accept.
REQ-020 SHALL accept at most one request per cycle; acceptance = req && addr_ok in the same cycle.
REQ-021 SHALL index memory with addr[ADDR_BITS+1:2]; addr[1:0] and addr[31:ADDR_BITS+2] ignored (higher addresses alias).
REQ-022 On an accepted write, SHALL update only the bytes enabled by wstrb at the accepting clock edge; wstrb = 0 writes nothing but still produces a data_ok.
REQ-023 On an accepted read, SHALL sample the memory word at the accepting edge, including any write accepted in an earlier cycle.
REQ-024 For a request accepted in cycle k, SHALL drive data_ok high in cycle k+LATENCY for exactly one cycle.
REQ-025 SHALL drive rdata = sampled word for reads and 32'h0 for writes while data_ok is high, and 32'h0 while data_ok is low.
REQ-026 SHALL implement the response path as a LATENCY-stage non-stalling shift pipeline (valid, wr, data); data_ok has no backpressure and is never dropped or reordered.
REQ-027 pending SHALL increment on accept, decrement on data_ok, and stay unchanged when both happen in the same cycle; maximum value is LATENCY.
REQ-028 Back-to-back accepts in consecutive cycles SHALL produce data_ok in consecutive cycles (full throughput).
REQ-029 Raising stall_en SHALL NOT affect requests already accepted; their responses complete on schedule.

Reset
REQ-030 While reset is high at a rising edge: addr_ok low in the following cycle, data_ok low, rdata 0, pending 0, all pipeline valid bits cleared, LFSR = LFSR_SEED.
REQ-031 Reset mid-operation SHALL discard all in-flight responses; no data_ok for them after reset.
REQ-032 Memory contents SHALL NOT be reset and are undefined until written.
REQ-033 While reset is high, SHALL ignore req, perform no memory write, and hold addr_ok low.

Verification
REQ-034 LATENCY=2: write 0x12345678 to 0x100 (wstrb 1111), then read 0x100 -> write data_ok 2 cycles after accept with rdata 0; read data_ok 2 cycles after its accept with rdata 0x12345678.
REQ-035 Partial write wstrb 0100, wdata 0x00AB0000 to 0x100 after REQ-034 -> read returns 0x12AB5678; read of 0x100+(4<<ADDR_BITS) returns the same (alias).
REQ-036 Four back-to-back reads at cycles 10..13 -> data_ok high in cycles 12..15 in order, pending peaks at 2.
REQ-037 stall_en high for 5 cycles with req held -> no accept, pending 0; on release, accept next cycle and data_ok LATENCY cycles later.
REQ-038 rand_en high, 200 random requests -> accept count equals data_ok count, order preserved, each read matches a scoreboard model.
REQ-039 Reset asserted one cycle after a read is accepted -> no data_ok observed afterwards, pending 0, addr_ok low during reset.

Source files
------------

// File: rtl/sram_like_responder_if.sv
// Initiator/responder bus for the SRAM-like responder: request channel plus
// the addr_ok acceptance and data_ok/rdata response.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (
    output req, wr, wstrb, addr, size, wdata,
    input  addr_ok, rdata, data_ok
  );

  modport slave (
    input  req, wr, wstrb, addr, size, wdata,
    output addr_ok, rdata, data_ok
  );
endinterface

// File: rtl/sram_like_responder.sv
// Word-addressed memory behind an SRAM-like handshake. The response comes back
// after a fixed LATENCY, and addr_ok can be throttled by stall or by an LFSR.
module sram_like_responder #(
  parameter int          ADDR_BITS = 12,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_like_responder_if.slave  bus,
  input  logic                  stall_en,
  input  logic                  rand_en,
  output logic [3:0]            pending
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Fibonacci feedback for taps 16,14,13,11
  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

  logic [15:0]          lfsr_r;
  logic                 accept_s;
  logic                 data_ok_s;
  logic [ADDR_BITS-1:0] idx_s;
  logic [31:0]          mem_r [DEPTH];
  logic [LATENCY-1:0]   vld_r;
  logic [LATENCY-1:0]   wr_r;
  logic [31:0]          dat_r [LATENCY];
  logic [3:0]           pending_r;
  logic                 unused_s;

  assign bus.addr_ok = !reset && !stall_en && (!rand_en || lfsr_r[0]);
  assign accept_s    = bus.req && bus.addr_ok;
  assign idx_s       = bus.addr[ADDR_BITS+1:2];
  assign unused_s    = ^{bus.size, bus.addr[31:ADDR_BITS+2], bus.addr[1:0]};

  assign data_ok_s   = vld_r[LATENCY-1];
  assign bus.data_ok = data_ok_s;
  assign bus.rdata   = (data_ok_s && !wr_r[LATENCY-1]) ? dat_r[LATENCY-1] : 32'h0;
  assign pending     = pending_r;

  // Throttle LFSR, free-running
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
    end
  end

  // Byte-lane memory write; contents are never reset
  always_ff @(posedge clk) begin
    if (accept_s && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_r[idx_s][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response shift pipeline; reads sample the pre-edge word
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= '0;
      wr_r  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_r[i] <= 32'h0;
      end
    end else begin
      vld_r[0] <= accept_s;
      wr_r[0]  <= accept_s && bus.wr;
      dat_r[0] <= (accept_s && !bus.wr) ? mem_r[idx_s] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        wr_r[i]  <= wr_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  // Outstanding-request counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 4'd0;
    end else begin
      case ({accept_s, data_ok_s})
        2'b10:   pending_r <= pending_r + 4'd1;
        2'b01:   pending_r <= pending_r - 4'd1;
        default: pending_r <= pending_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: a negedge monitor scoreboards every
// response against a byte-lane memory model, and directed steps check known values.
module tb_sram_like_responder;

  localparam int AB  = 12;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    logic        wr;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic stall_en;
  logic rand_en;
  logic [3:0] pending;

  sram_like_responder_if bus ();

  sram_like_responder #(.ADDR_BITS(AB), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .stall_en (stall_en),
    .rand_en  (rand_en),
    .pending  (pending)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          acc_cnt = 0;
  int          ok_cnt  = 0;
  int          peak    = 0;
  logic        mon_en  = 1'b0;
  logic [31:0] last_rd = 32'h0;
  exp_t        q [$];
  logic [31:0] model [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge
  initial forever begin
    exp_t e;
    int   key;
    @(negedge clk);
    if (mon_en) begin
      chk_eq("pending", {28'd0, pending}, q.size());
      if (int'(pending) > peak) peak = int'(pending);
      if (bus.data_ok) begin
        ok_cnt++;
        if (q.size() == 0) begin
          chk_eq("spurious_data_ok", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk_eq("rdata", bus.rdata, e.data);
          chk_eq("latency", cyc - e.cyc, LAT);
          if (!e.wr) last_rd = bus.rdata;
        end
      end else begin
        chk_eq("rdata_idle", bus.rdata, 32'h0);
      end
      if (reset) begin
        chk_eq("addr_ok_in_reset", {31'd0, bus.addr_ok}, 32'd0);
        q.delete();
      end else if (bus.req && bus.addr_ok) begin
        acc_cnt++;
        key    = int'(bus.addr[AB+1:2]);
        e.wr   = bus.wr;
        e.cyc  = cyc;
        e.data = 32'h0;
        if (bus.wr) begin
          if (!model.exists(key)) model[key] = 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.wstrb[b]) model[key][8*b +: 8] = bus.wdata[8*b +: 8];
        end else begin
          e.data = model.exists(key) ? model[key] : 32'hxxxx_xxxx;
        end
        q.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted
  task automatic do_req(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.req = 1'b1; bus.wr = w; bus.wstrb = s; bus.addr = a; bus.wdata = d; bus.size = 3'd2;
    @(negedge clk);
    while (!bus.addr_ok && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.addr_ok) chk_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int a0, o0, n, idx;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;

    reset = 1'b1; stall_en = 1'b0; rand_en = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.wstrb = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.size = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
    chk_eq("rst_data_ok", {31'd0, bus.data_ok}, 32'd0);
    chk_eq("rst_rdata", bus.rdata, 32'h0);
    chk_eq("rst_pending", {28'd0, pending}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Full write then read
    do_req(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0);
    idle(4);
    chk_eq("rd_full_word", last_rd, 32'h1234_5678);

    // Partial write and aliased read
    do_req(1'b1, 4'b0100, 32'h0000_0100, 32'h00AB_0000);
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0);
    idle(4);
    chk_eq("rd_partial", last_rd, 32'h12AB_5678);
    do_req(1'b0, 4'h0, 32'h0000_0100 + (32'd4 << AB), 32'h0);
    idle(4);
    chk_eq("rd_alias", last_rd, 32'h12AB_5678);

    // Zero strobe writes nothing but still responds
    o0 = ok_cnt;
    do_req(1'b1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF);
    do_req(1'b0, 4'h0, 32'h0000_0102, 32'h0);
    idle(4);
    chk_eq("wstrb0_ok_count", ok_cnt - o0, 32'd2);
    chk_eq("wstrb0_no_write", last_rd, 32'h12AB_5678);

    // Back-to-back reads
    do_req(1'b1, 4'hF, 32'h0000_0104, 32'hA5A5_0001);
    do_req(1'b1, 4'hF, 32'h0000_0108, 32'hA5A5_0002);
    do_req(1'b1, 4'hF, 32'h0000_010C, 32'hA5A5_0003);
    idle(4);
    peak = 0;
    o0 = ok_cnt;
    for (int i = 0; i < 4; i++) do_req(1'b0, 4'h0, 32'h0000_0100 + 32'(i * 4), 32'h0);
    idle(4);
    chk_eq("b2b_ok_count", ok_cnt - o0, 32'd4);
    chk_eq("b2b_peak_pending", peak, 32'd2);
    chk_eq("b2b_last_rd", last_rd, 32'hA5A5_0003);

    // Stall with request held
    a0 = acc_cnt;
    stall_en = 1'b1;
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h0000_0108; bus.wstrb = 4'h0;
    idle(5);
    chk_eq("stall_no_accept", acc_cnt - a0, 32'd0);
    chk_eq("stall_pending", {28'd0, pending}, 32'd0);
    stall_en = 1'b0;
    idle(1);
    bus.req = 1'b0;
    chk_eq("stall_release_accept", acc_cnt - a0, 32'd1);
    idle(4);
    chk_eq("stall_release_rd", last_rd, 32'hA5A5_0002);

    // Random throttling with random traffic
    rand_en = 1'b1;
    a0 = acc_cnt;
    o0 = ok_cnt;
    for (int i = 0; i < 200; i++) begin
      idx = int'($urandom_range(0, 7));
      a   = ($urandom() & 32'hFFFF_C003) | (32'h0000_0100 + 32'(idx * 4));
      w   = 1'($urandom_range(0, 1));
      s   = 4'($urandom_range(0, 15));
      if (!w && !model.exists(int'(a[AB+1:2]))) begin
        w = 1'b1;
        s = 4'hF;
      end
      do_req(w, s, a, $urandom());
    end
    rand_en = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      idle(1);
    end
    idle(1);
    chk_eq("rand_drain", q.size(), 32'd0);
    chk_eq("rand_accept_eq_ok", ok_cnt - o0, acc_cnt - a0);

    // Reset one cycle after a read is accepted
    do_req(1'b0, 4'h0, 32'h0000_0100, 32'h0);
    o0 = ok_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk_eq("mid_rst_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
    @(posedge clk);
    #1;
    chk_eq("mid_rst_addr_ok2", {31'd0, bus.addr_ok}, 32'd0);
    idle(1);
    reset = 1'b0;
    idle(5);
    chk_eq("mid_rst_no_data_ok", ok_cnt - o0, 32'd0);
    chk_eq("mid_rst_pending", {28'd0, pending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
